// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu : load/store unit bridging a core port to a word-wide data memory
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lsu #(
  parameter int DATA_MEM_SIZE_BYTES = 512
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] rd_q;
  logic        illegal;
  logic        in_req;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wd_rep;

  // Legality is judged on the live inputs so ERR is entered directly from IDLE
  always_comb begin
    illegal = 1'b0;
    if (core_size_i == 3'b011 || core_size_i == 3'b110 || core_size_i == 3'b111)
      illegal = 1'b1;
    if (core_we_i && core_size_i[2])
      illegal = 1'b1;
    if (core_size_i[1:0] == 2'b01 && core_addr_i[0])
      illegal = 1'b1;
    if (core_size_i == 3'b010 && core_addr_i[1:0] != 2'b00)
      illegal = 1'b1;
    if (core_addr_i >= 32'(DATA_MEM_SIZE_BYTES))
      illegal = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (core_req_i) state_nxt = illegal ? ERR : REQ;
      REQ:     if (mem_ready_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      size_q <= 3'b000;
      addr_q <= 32'd0;
      wd_q   <= 32'd0;
      rd_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && core_req_i) begin
        we_q   <= core_we_i;
        size_q <= core_size_i;
        addr_q <= core_addr_i;
        wd_q   <= core_wd_i;
      end
      if (state == REQ && mem_ready_i && !we_q)
        rd_q <= load_val;
    end
  end

  assign lane = mem_rd_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = lane;
    case (size_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    be     = 4'b1111;
    wd_rep = wd_q;
    case (size_q[1:0])
      2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        wd_rep = {4{wd_q[7:0]}};
      end
      2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{wd_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = wd_q;
      end
    endcase
  end

  // Memory side is driven only in REQ so reset or an error leaves it quiet
  assign in_req       = (state == REQ);
  assign mem_req_o    = in_req;
  assign mem_we_o     = in_req & we_q;
  assign mem_be_o     = in_req ? be : 4'b0000;
  assign mem_addr_o   = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wd_o     = in_req ? wd_rep : 32'd0;

  assign core_rd_o    = rd_q;
  assign core_err_o   = (state == ERR);
  assign core_stall_o = core_req_i & (state != DONE) & (state != ERR);

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu : scoreboard bench for the lsu block
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [2:0]  core_size = 3'b000;
  logic [31:0] core_addr = 32'd0;
  logic [31:0] core_wd = 32'd0;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        core_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = 32'd0;
  logic        mem_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          err;
    bit          load;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] addr;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd = 32'd0;

  always #5 clk = ~clk;

  lsu #(.DATA_MEM_SIZE_BYTES(512)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd), .core_rd_o(core_rd),
    .core_stall_o(core_stall), .core_err_o(core_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input bit we, input logic [2:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int dly);
    exp_t e;
    logic [7:0]  b;
    logic [15:0] h;
    e.err  = (sz == 3'b011) || (sz == 3'b110) || (sz == 3'b111) ||
             (we && (sz == 3'b100 || sz == 3'b101)) ||
             ((sz == 3'b001 || sz == 3'b101) && a[0]) ||
             (sz == 3'b010 && a[1:0] != 2'b00) || (a >= 32'd512);
    e.load = !we;
    e.addr = {a[31:2], 2'b00};
    b = rdata[8*a[1:0] +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      3'b000:  begin e.be = 4'b0001 << a[1:0]; e.wd = {4{wd[7:0]}}; e.rd = {{24{b[7]}}, b}; end
      3'b100:  begin e.be = 4'b0001 << a[1:0]; e.wd = {4{wd[7:0]}}; e.rd = {24'd0, b}; end
      3'b001:  begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wd = {2{wd[15:0]}}; e.rd = {{16{h[15]}}, h}; end
      3'b101:  begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wd = {2{wd[15:0]}}; e.rd = {16'd0, h}; end
      default: begin e.be = 4'b1111; e.wd = wd; e.rd = rdata; end
    endcase
    if (we || e.err) e.rd = last_rd;
    e.stalls = e.err ? 1 : 2 + dly;
    return e;
  endfunction

  // Drives one access starting on a negedge; memory answers after dly REQ cycles
  task automatic access(input bit we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input int dly);
    exp_t e;
    int   stalls;
    bit   finished;
    bit   req_seen;
    sb.push_back(model(we, sz, a, wd, rdata, dly));
    core_req  = 1'b1;
    core_we   = we;
    core_size = sz;
    core_addr = a;
    core_wd   = wd;
    #1;
    chk("stall_idle", 32'(core_stall), 32'd1);
    stalls   = 1;
    finished = 1'b0;
    req_seen = 1'b0;
    e = sb[0];
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (core_err || !core_stall) begin
        finished = 1'b1;
        break;
      end
      stalls++;
      req_seen = req_seen | mem_req;
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(we));
      chk("mem_be", 32'(mem_be), 32'(e.be));
      chk("mem_addr", mem_addr, e.addr);
      if (we) chk("mem_wd", mem_wd, e.wd);
      mem_ready = (c == dly);
      mem_rd    = (c == dly) ? rdata : 32'hA5A5_5A5A;
    end
    mem_ready = 1'b0;
    chk("finished", 32'(finished), 32'd1);
    e = sb.pop_front();
    chk("err", 32'(core_err), 32'(e.err));
    chk("stalls", 32'(stalls), 32'(e.stalls));
    chk("mem_req_end", 32'(mem_req), 32'd0);
    if (e.err) chk("err_no_mem", 32'(req_seen), 32'd0);
    chk("core_rd", core_rd, e.rd);
    last_rd  = e.rd;
    core_req = 1'b0;
    @(negedge clk);
    chk("err_pulse", 32'(core_err), 32'd0);
    chk("rd_hold", core_rd, e.rd);
  endtask

  initial begin
    #2;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_rd", core_rd, 32'd0);
    chk("rst_err", 32'(core_err), 32'd0);
    core_req = 1'b1;
    #1;
    chk("rst_stall", 32'(core_stall), 32'd1);
    core_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    access(1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF_FFFF, 0);
    access(1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF_FFFF, 1);
    access(1'b0, 3'b101, 32'h12, 32'h0, 32'h8001_0000, 0);
    access(1'b0, 3'b001, 32'h6,  32'h0, 32'h9234_5678, 2);
    access(1'b1, 3'b000, 32'h21, 32'hAB, 32'h0, 0);
    access(1'b1, 3'b001, 32'h22, 32'h1234, 32'h0, 0);
    access(1'b0, 3'b010, 32'h2,  32'h0, 32'h0, 0);
    access(1'b0, 3'b001, 32'h5,  32'h0, 32'h0, 0);
    access(1'b1, 3'b010, 32'h200, 32'h1, 32'h0, 0);
    access(1'b0, 3'b011, 32'h8,  32'h0, 32'h0, 0);
    access(1'b1, 3'b100, 32'h8,  32'h7, 32'h0, 0);
    access(1'b1, 3'b010, 32'h1FC, 32'hCAFE_F00D, 32'h0, 4);

    // mem_ready outside REQ must be ignored
    mem_ready = 1'b1;
    mem_rd    = 32'h1111_1111;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("idle_ready_req", 32'(mem_req), 32'd0);
    chk("idle_ready_rd", core_rd, last_rd);

    // async reset during REQ abandons the access
    core_req  = 1'b1;
    core_we   = 1'b1;
    core_size = 3'b010;
    core_addr = 32'h40;
    core_wd   = 32'h1234_5678;
    @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(mem_req), 32'd0);
    chk("async_we", 32'(mem_we), 32'd0);
    chk("async_addr", mem_addr, 32'd0);
    chk("async_wd", mem_wd, 32'd0);
    chk("async_rd", core_rd, 32'd0);
    chk("async_stall", 32'(core_stall), 32'd1);
    core_req = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_err", 32'(core_err), 32'd0);
      chk("post_rst_req", 32'(mem_req), 32'd0);
      chk("post_rst_rd", core_rd, 32'd0);
      @(negedge clk);
    end
    last_rd = 32'd0;
    access(1'b0, 3'b010, 32'h44, 32'h0, 32'h0BAD_F00D, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
